// File: rtl/arb_wrr_pkt.sv
// rtl/arb_wrr_pkt.sv - packet-atomic weighted round-robin arbiter with one registered output stage
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   v_vld_s  [WIDTH]     per-requester beat valid
//   v_rdy_s  [WIDTH]     per-requester beat ready (onehot grant gated by load enable)
//   v_last_s [WIDTH]     per-requester last beat of packet
//   v_pld_s  [WIDTH]     per-requester payload, PLD_WIDTH bits each
//   v_weight [WIDTH]     packets per turn per requester (0 behaves as 1)
//   vld_m, rdy_m         downstream beat valid / ready
//   pld_m, last_m, id_m  downstream payload, last flag, owning requester index
module arb_wrr_pkt #(
  parameter int WIDTH     = 4,
  parameter int PLD_WIDTH = 32,
  parameter int WGT_WIDTH = 4,
  localparam int IDW      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     v_vld_s,
  output logic [WIDTH-1:0]     v_rdy_s,
  input  logic [WIDTH-1:0]     v_last_s,
  input  logic [PLD_WIDTH-1:0] v_pld_s  [WIDTH],
  input  logic [WGT_WIDTH-1:0] v_weight [WIDTH],
  output logic                 vld_m,
  input  logic                 rdy_m,
  output logic [PLD_WIDTH-1:0] pld_m,
  output logic                 last_m,
  output logic [IDW-1:0]       id_m
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [IDW-1:0]       ptr;
  logic [IDW-1:0]       ptr_nxt;
  logic [WGT_WIDTH-1:0] cnt;
  logic [WGT_WIDTH-1:0] cnt_nxt;

  logic                 ld;
  logic                 gnt_any;
  logic [IDW-1:0]       gnt_idx;
  logic [IDW-1:0]       cand;
  logic                 acc;
  logic                 beat_last;
  logic [WGT_WIDTH-1:0] cnt_base;
  logic [WGT_WIDTH:0]   cnt_inc;
  logic [WGT_WIDTH:0]   ew_ext;

  assign ld        = ~vld_m | rdy_m;
  assign acc       = gnt_any & ld;
  assign beat_last = v_last_s[gnt_idx];

  // Winner selection. While locked, ptr holds the packet owner, so only
  // that requester may win. Otherwise search ptr, ptr+1, ... and keep the
  // closest valid one; the loop runs from the far end so nearer hits win.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr;
    cand    = ptr;
    if (state == S_LOCK) begin
      gnt_any = v_vld_s[ptr];
    end else begin
      for (int k = WIDTH - 1; k >= 0; k--) begin
        cand = IDW'((32'(ptr) + 32'(k)) % WIDTH);
        if (v_vld_s[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  // State, pointer and turn counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: lock on a non-last first beat, unlock on the owner's last beat.
  // A single-beat packet leaves the FSM in IDLE.
  always_comb begin
    state_nxt = state;
    if (acc) begin
      if (state == S_IDLE && !beat_last) state_nxt = S_LOCK;
      if (state == S_LOCK &&  beat_last) state_nxt = S_IDLE;
    end
  end

  // Turn bookkeeping. A first beat from someone other than ptr starts a fresh
  // turn (count 0); the weight is only looked at when a packet completes.
  always_comb begin
    cnt_base = (state == S_IDLE && gnt_idx != ptr) ? '0 : cnt;
    ew_ext   = (v_weight[gnt_idx] == '0) ? (WGT_WIDTH+1)'(1) : {1'b0, v_weight[gnt_idx]};
    cnt_inc  = {1'b0, cnt_base} + (WGT_WIDTH+1)'(1);
    ptr_nxt  = ptr;
    cnt_nxt  = cnt;
    if (acc) begin
      ptr_nxt = gnt_idx;
      cnt_nxt = cnt_base;
      if (beat_last) begin
        if (cnt_inc >= ew_ext) begin
          ptr_nxt = (gnt_idx == IDW'(WIDTH - 1)) ? '0 : gnt_idx + IDW'(1);
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt_inc[WGT_WIDTH-1:0];
        end
      end
    end
  end

  // Ready is forced low during reset even though ld is high then.
  always_comb begin
    v_rdy_s = '0;
    if (acc && rst_n) v_rdy_s = WIDTH'(1) << gnt_idx;
  end

  // Output stage: payload fields only move when a new beat is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_m  <= 1'b0;
      pld_m  <= '0;
      last_m <= 1'b0;
      id_m   <= '0;
    end else if (ld) begin
      vld_m <= acc;
      if (acc) begin
        pld_m  <= v_pld_s[gnt_idx];
        last_m <= beat_last;
        id_m   <= gnt_idx;
      end
    end
  end

endmodule
